// File: rtl/sa_feed_sequencer.sv
// Feed sequencer for a 4x4 systolic array: preloads a weight tile from the north,
// streams the diagonally skewed feature tile from the west, then flushes with zeros.
module sa_feed_sequencer #(
    parameter int DW           = 8,
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*DW-1:0] a_rdata,
    input  logic [N-1:0]    a_empty,
    output logic [N-1:0]    a_rd_en,
    input  logic [N*DW-1:0] w_rdata,
    input  logic [N-1:0]    w_empty,
    output logic [N-1:0]    w_rd_en,
    output logic [N*DW-1:0] north_data,
    output logic [N*DW-1:0] west_data,
    output logic            w_load,
    output logic            sa_en,
    output logic            stall,
    output logic            busy,
    output logic            done
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD_W | popping one weight row per cycle, c = 0..N-1
    // FEED   | skewed feature injection, t = 0..2N-2
    // DRAIN  | zero-input flush, DRAIN_CYCLES cycles
    // DONE   | one-cycle done pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CMAX = (2 * N > DRAIN_CYCLES) ? 2 * N : DRAIN_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*DW-1:0] north_q, north_d;
    logic [N*DW-1:0] west_q, west_d;
    logic            w_load_q, w_load_d;
    logic            sa_en_q, sa_en_d;
    logic            stall_q, stall_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N-1:0]    active;
    logic            a_ready;
    logic            w_ready;

    // Lane r carries feature words during steps r..r+N-1, giving the diagonal skew.
    always_comb begin
        active = '0;
        for (int r = 0; r < N; r++) begin
            active[r] = (int'(cnt_q) >= r) && (int'(cnt_q) <= r + N - 1);
        end
    end

    // Empty flags of lanes outside the active window must not stall the array.
    assign a_ready = ((active & a_empty) == '0);
    assign w_ready = (w_empty == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        north_d  = north_q;
        west_d   = west_q;
        w_load_d = 1'b0;
        sa_en_d  = 1'b0;
        stall_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        a_rd_en  = '0;
        w_rd_en  = '0;

        case (state_q)
            S_IDLE: begin
                north_d = '0;
                west_d  = '0;
                if (start) begin
                    state_d = S_LOAD_W;
                    cnt_d   = '0;
                end
            end

            S_LOAD_W: begin
                busy_d = 1'b1;
                west_d = '0;
                if (w_ready) begin
                    w_rd_en  = '1;
                    north_d  = w_rdata;
                    w_load_d = 1'b1;
                    sa_en_d  = 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_FEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    stall_d = 1'b1;
                end
            end

            S_FEED: begin
                busy_d  = 1'b1;
                north_d = '0;
                if (a_ready) begin
                    a_rd_en = active;
                    for (int r = 0; r < N; r++) begin
                        west_d[r*DW +: DW] = active[r] ? a_rdata[r*DW +: DW] : '0;
                    end
                    sa_en_d = 1'b1;
                    if (cnt_q == CW'(2 * N - 2)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    stall_d = 1'b1;
                end
            end

            S_DRAIN: begin
                busy_d  = 1'b1;
                north_d = '0;
                west_d  = '0;
                sa_en_d = 1'b1;
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                north_d = '0;
                west_d  = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pops are suppressed during reset so an aborted tile leaves FIFOs untouched.
        if (rst) begin
            a_rd_en = '0;
            w_rd_en = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            north_q  <= '0;
            west_q   <= '0;
            w_load_q <= 1'b0;
            sa_en_q  <= 1'b0;
            stall_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            north_q  <= north_d;
            west_q   <= west_d;
            w_load_q <= w_load_d;
            sa_en_q  <= sa_en_d;
            stall_q  <= stall_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign north_data = north_q;
    assign west_data  = west_q;
    assign w_load     = w_load_q;
    assign sa_en      = sa_en_q;
    assign stall      = stall_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sa_feed_sequencer.sv
// Directed bench for sa_feed_sequencer: FWFT FIFO models feed the DUT and a
// per-lane scoreboard checks every weight/feature word that reaches the array.
module tb_sa_feed_sequencer;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int D  = 7;

    logic            clk;
    logic            rst;
    logic            start;
    logic [N*DW-1:0] a_rdata;
    logic [N-1:0]    a_empty;
    logic [N-1:0]    a_rd_en;
    logic [N*DW-1:0] w_rdata;
    logic [N-1:0]    w_empty;
    logic [N-1:0]    w_rd_en;
    logic [N*DW-1:0] north_data;
    logic [N*DW-1:0] west_data;
    logic            w_load;
    logic            sa_en;
    logic            stall;
    logic            busy;
    logic            done;

    sa_feed_sequencer #(.DW(DW), .N(N), .DRAIN_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_rdata   (a_rdata),
        .a_empty   (a_empty),
        .a_rd_en   (a_rd_en),
        .w_rdata   (w_rdata),
        .w_empty   (w_empty),
        .w_rd_en   (w_rd_en),
        .north_data(north_data),
        .west_data (west_data),
        .w_load    (w_load),
        .sa_en     (sa_en),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] a_fifo [N][$];
    logic [DW-1:0] w_fifo [N][$];
    logic [DW-1:0] exp_n  [N][$];
    logic [DW-1:0] exp_w  [N][$];
    logic [N-1:0]  a_force;
    logic [N-1:0]  w_force;
    int            a_pops [N];
    int            w_pops [N];
    int            checks;
    int            errors;
    int            cyc;
    int            done_cnt;
    int            done_at [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            a_empty[r] = a_force[r] || (a_fifo[r].size() == 0);
            w_empty[r] = w_force[r] || (w_fifo[r].size() == 0);
            a_rdata[r*DW +: DW] = (a_fifo[r].size() > 0) ? a_fifo[r][0] : '0;
            w_rdata[r*DW +: DW] = (w_fifo[r].size() > 0) ? w_fifo[r][0] : '0;
        end
        #1;
    endtask

    task automatic push_w(input int r, input logic [DW-1:0] v);
        w_fifo[r].push_back(v);
        exp_n[r].push_back(v);
    endtask

    task automatic push_a(input int r, input logic [DW-1:0] v);
        a_fifo[r].push_back(v);
        exp_w[r].push_back(v);
    endtask

    task automatic fill_std();
        for (int r = 0; r < N; r++) begin
            for (int k = 1; k <= N; k++) begin
                push_w(r, DW'(10 * r + k));
                push_a(r, DW'(20 * r + k));
            end
        end
        drive();
    endtask

    task automatic clear_all();
        for (int r = 0; r < N; r++) begin
            a_fifo[r].delete();
            w_fifo[r].delete();
            exp_n[r].delete();
            exp_w[r].delete();
            a_pops[r] = 0;
            w_pops[r] = 0;
        end
        done_cnt = 0;
        drive();
    endtask

    // One clock: underflow check, edge, FIFO pops, then scoreboard on the new outputs.
    task automatic step();
        logic [N-1:0] ar;
        logic [N-1:0] wr;
        #1;
        ar = a_rd_en;
        wr = w_rd_en;
        chk("a_underflow", 32'(ar & a_empty), 32'h0);
        chk("w_underflow", 32'(wr & w_empty), 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < N; r++) begin
            if (ar[r] && a_fifo[r].size() > 0) begin
                void'(a_fifo[r].pop_front());
                a_pops[r]++;
            end
            if (wr[r] && w_fifo[r].size() > 0) begin
                void'(w_fifo[r].pop_front());
                w_pops[r]++;
            end
        end
        drive();
        for (int r = 0; r < N; r++) begin
            if (w_load) begin
                chk($sformatf("north_sb_lane%0d", r), 32'(north_data[r*DW +: DW]),
                    (exp_n[r].size() > 0) ? 32'(exp_n[r].pop_front()) : 32'hDEAD);
            end
            if (sa_en && west_data[r*DW +: DW] != '0) begin
                chk($sformatf("west_sb_lane%0d", r), 32'(west_data[r*DW +: DW]),
                    (exp_w[r].size() > 0) ? 32'(exp_w[r].pop_front()) : 32'hDEAD);
            end
        end
        if (done) begin
            if (done_cnt < 3) done_at[done_cnt] = cyc;
            done_cnt++;
        end
    endtask

    task automatic start_tile();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int last, input int done_cyc);
        while (cyc < last) begin
            step();
            chk("done_pulse", 32'(done), 32'(cyc == done_cyc));
        end
    endtask

    task automatic tile_end(input int pops);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("a_pops_lane%0d", r), 32'(a_pops[r]), 32'(pops));
            chk($sformatf("w_pops_lane%0d", r), 32'(w_pops[r]), 32'(pops));
            chk($sformatf("exp_left_lane%0d", r), 32'(exp_n[r].size() + exp_w[r].size()), 32'h0);
        end
        chk("done_count", 32'(done_cnt), 32'(pops / N));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a_force = '0;
        w_force = '0;
        clear_all();
        step();
        step();
        chk("rst_w_rd_en", 32'(w_rd_en), 32'h0);
        rst = 1'b0;
        chk("rst_north", 32'(north_data), 32'h0);
        chk("rst_west", 32'(west_data), 32'h0);
        chk("rst_ctrl", {27'h0, w_load, sa_en, stall, busy, done}, 32'h0);

        // Nominal tile
        clear_all();
        fill_std();
        start_tile();
        while (cyc < 21) begin
            step();
            chk("t1_w_load", 32'(w_load), 32'(cyc >= 1 && cyc <= 4));
            if (cyc >= 1 && cyc <= 4)
                chk("t1_north1", 32'(north_data[15:8]), 32'(10 + cyc));
            chk("t1_west2", 32'(west_data[23:16]), (cyc >= 7 && cyc <= 10) ? 32'(34 + cyc) : 32'h0);
            chk("t1_busy", 32'(busy), 32'(cyc >= 1 && cyc <= 18));
            chk("t1_done", 32'(done), 32'(cyc == 19));
            chk("t1_stall", 32'(stall), 32'h0);
        end
        tile_end(4);

        // Weight lane 3 empty for three LOAD_W cycles
        clear_all();
        fill_std();
        start_tile();
        step();
        chk("t2_first_load", 32'(w_load), 32'h1);
        w_force = 4'b1000;
        drive();
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_wpop", 32'(w_rd_en), 32'h0);
            step();
            chk("t2_stall", {29'h0, stall, sa_en, w_load}, 32'h4);
            chk("t2_north_hold", 32'(north_data[7:0]), 32'h1);
        end
        w_force = '0;
        drive();
        run_to(24, 22);
        tile_end(4);

        // Inactive lane 0 empty at t=4: no stall
        clear_all();
        fill_std();
        start_tile();
        run_to(8, -1);
        a_force = 4'b0001;
        drive();
        chk("t3_pop_mask", 32'(a_rd_en), 32'hE);
        step();
        chk("t3_no_stall", {30'h0, stall, sa_en}, 32'h1);
        a_force = '0;
        drive();
        run_to(20, 19);
        tile_end(4);

        // Active lane 1 empty at t=4: one stall, west holds
        clear_all();
        fill_std();
        start_tile();
        run_to(8, -1);
        a_force = 4'b0010;
        drive();
        chk("t3b_no_pops", 32'(a_rd_en), 32'h0);
        step();
        chk("t3b_stall", {30'h0, stall, sa_en}, 32'h2);
        chk("t3b_hold1", 32'(west_data[15:8]), 32'd23);
        chk("t3b_hold2", 32'(west_data[23:16]), 32'd42);
        a_force = '0;
        drive();
        step();
        chk("t3b_resume", 32'(west_data[15:8]), 32'd24);
        run_to(22, 20);
        tile_end(4);

        // start held high: three back-to-back tiles
        clear_all();
        fill_std();
        fill_std();
        fill_std();
        start = 1'b1;
        step();
        cyc = 0;
        while (done_cnt < 3 && cyc < 80) begin
            step();
            if (done_cnt == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("t4_tiles", 32'(done_cnt), 32'd3);
        chk("t4_done0", 32'(done_at[0]), 32'd19);
        chk("t4_done1", 32'(done_at[1]), 32'd39);
        chk("t4_done2", 32'(done_at[2]), 32'd59);
        step();
        step();
        chk("t4_idle", 32'(busy), 32'h0);
        tile_end(12);

        // Reset at FEED t=2
        clear_all();
        fill_std();
        start_tile();
        run_to(6, -1);
        rst = 1'b1;
        #1;
        chk("t5_rst_apop", 32'(a_rd_en), 32'h0);
        chk("t5_rst_wpop", 32'(w_rd_en), 32'h0);
        step();
        rst = 1'b0;
        chk("t5_north", 32'(north_data), 32'h0);
        chk("t5_west", 32'(west_data), 32'h0);
        chk("t5_ctrl", {27'h0, w_load, sa_en, stall, busy, done}, 32'h0);
        chk("t5_a0_left", 32'(a_fifo[0].size()), 32'd2);
        chk("t5_a1_left", 32'(a_fifo[1].size()), 32'd3);
        chk("t5_a3_left", 32'(a_fifo[3].size()), 32'd4);
        step();
        chk("t5_idle", 32'(busy), 32'h0);
        clear_all();
        fill_std();
        start_tile();
        while (cyc < 20) begin
            step();
            chk("t5_w_load", 32'(w_load), 32'(cyc >= 1 && cyc <= 4));
            chk("t5_done", 32'(done), 32'(cyc == 19));
        end
        tile_end(4);

        // Negative data passes bit-exact
        clear_all();
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                push_w(r, 8'h80);
                push_a(r, 8'hFF);
            end
        end
        drive();
        start_tile();
        step();
        chk("t6_north3", 32'(north_data[31:24]), 32'h80);
        run_to(4, -1);
        step();
        chk("t6_west0", 32'(west_data[7:0]), 32'hFF);
        chk("t6_west1", 32'(west_data[15:8]), 32'h0);
        run_to(20, 19);
        tile_end(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
